// File: rtl/biquad8_coeff_loader.sv
// Wishbone-master sequencer: replays a staged coefficient set to every biquad selected
// in a target mask, then optionally pulses the shared global coefficient update.
module biquad8_coeff_loader #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned NTARGET     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        ld_we_i,
    input  logic [4:0]  ld_adr_i,
    input  logic [22:0] ld_dat_i,
    input  logic        start_i,
    input  logic [5:0]  count_i,
    input  logic [15:0] target_mask_i,
    input  logic        update_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        global_update_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [10:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        FETCH,
        ISSUE,
        GAP,
        UPDATE,
        DONE
    } state_t;

    state_t         state_q;
    logic [22:0]    ram_q [DEPTH];
    logic [22:0]    word_q;
    logic [5:0]     count_q;
    logic [5:0]     idx_q;
    logic [5:0]     idx_d;
    logic [15:0]    mask_q;
    logic           upd_q;
    logic [3:0]     tgt_q;
    logic [3:0]     sel_d;
    logic [TW-1:0]  tmo_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic           gup_q;
    logic           cyc_q;

    // Staging RAM: no reset, writable only while the sequencer is parked.
    always_ff @(posedge wb_clk_i) begin
        if (ld_we_i && state_q == IDLE) begin
            ram_q[ld_adr_i[AW-1:0]] <= ld_dat_i;
        end
    end

    // Lowest set bit of the remaining mask wins; the last assignment in the loop is the lowest.
    always_comb begin
        sel_d = '0;
        for (int unsigned i = 0; i < NTARGET; i++) begin
            if (mask_q[NTARGET-1-i]) begin
                sel_d = 4'(NTARGET - 1 - i);
            end
        end
    end

    assign idx_d = idx_q + 6'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            upd_q   <= 1'b0;
            tgt_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            gup_q   <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            gup_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_q <= count_i;
                        mask_q  <= target_mask_i;
                        upd_q   <= update_i;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (mask_q == '0) begin
                        gup_q   <= upd_q;
                        state_q <= UPDATE;
                    end else begin
                        tgt_q         <= sel_d;
                        mask_q[sel_d] <= 1'b0;
                        idx_q         <= '0;
                        state_q       <= (count_q == '0) ? SELECT : FETCH;
                    end
                end
                FETCH: begin
                    word_q  <= ram_q[idx_q[AW-1:0]];
                    cyc_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    // Bus error takes priority over a simultaneous ack.
                    if (wbm_err_i) begin
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (wbm_ack_i) begin
                        cyc_q   <= 1'b0;
                        state_q <= GAP;
                    end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                GAP: begin
                    idx_q   <= idx_d;
                    state_q <= (idx_d == count_q) ? SELECT : FETCH;
                end
                UPDATE: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign global_update_o = gup_q;
    assign wbm_cyc_o       = cyc_q;
    assign wbm_stb_o       = cyc_q;
    assign wbm_we_o        = cyc_q;
    assign wbm_adr_o       = {tgt_q, word_q[22:18], 2'b00};
    assign wbm_dat_o       = {14'b0, word_q[17:0]};
    assign wbm_sel_o       = 4'hF;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader with a latency-programmable Wishbone slave model.
module tb_biquad8_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_we_i = 1'b0;
    logic [4:0]  ld_adr_i = '0;
    logic [22:0] ld_dat_i = '0;
    logic        start_i = 1'b0;
    logic [5:0]  count_i = '0;
    logic [15:0] target_mask_i = '0;
    logic        update_i = 1'b0;
    logic        busy_o, done_o, err_o, global_update_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [10:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    biquad8_coeff_loader #(.ACK_TIMEOUT(4)) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .ld_we_i         (ld_we_i),
        .ld_adr_i        (ld_adr_i),
        .ld_dat_i        (ld_dat_i),
        .start_i         (start_i),
        .count_i         (count_i),
        .target_mask_i   (target_mask_i),
        .update_i        (update_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .global_update_o (global_update_o),
        .wbm_cyc_o       (wbm_cyc_o),
        .wbm_stb_o       (wbm_stb_o),
        .wbm_we_o        (wbm_we_o),
        .wbm_adr_o       (wbm_adr_o),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_sel_o       (wbm_sel_o),
        .wbm_ack_i       (wbm_ack_i),
        .wbm_err_i       (wbm_err_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Slave model and bus monitor, evaluated mid-cycle; counters only ever grow.
    int   lat = 0;
    logic ack_en = 1'b1;
    int   err_beat = -1;
    int   wcnt = 0, beat = 0;
    int   nwr = 0, rises = 0, cur_run = 0, gup_n = 0, done_n = 0, gup_cyc = 0, done_cyc = 0;
    logic stb_prev = 1'b0;
    logic [10:0] wr_adr [64];
    logic [31:0] wr_dat [64];
    int   runs [64];
    logic is_err, end_beat;

    assign is_err   = (beat == err_beat);
    assign end_beat = wbm_stb_o && (wcnt == lat) && (ack_en || is_err);

    always @(negedge clk) begin
        wbm_ack_i <= end_beat && !is_err;
        wbm_err_i <= end_beat && is_err;
        if (end_beat) begin
            wcnt <= 0;
            beat <= beat + 1;
            if (!is_err) begin
                wr_adr[nwr % 64] <= wbm_adr_o;
                wr_dat[nwr % 64] <= wbm_dat_o;
                nwr <= nwr + 1;
            end
        end else if (wbm_stb_o) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
        stb_prev <= wbm_stb_o;
        if (wbm_stb_o && !stb_prev) begin
            rises   <= rises + 1;
            cur_run <= 1;
        end else if (wbm_stb_o) begin
            cur_run <= cur_run + 1;
        end else if (stb_prev) begin
            runs[(rises - 1) % 64] <= cur_run;
        end
        if (global_update_o) begin
            gup_n   <= gup_n + 1;
            gup_cyc <= cyc_n;
        end
        if (done_o) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc_n;
        end
    end

    int b_nwr, b_rise, b_gup, b_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic stage(input logic [4:0] idx, input logic [4:0] off, input logic [17:0] coef);
        @(negedge clk);
        ld_we_i  = 1'b1;
        ld_adr_i = idx;
        ld_dat_i = {off, coef};
        @(negedge clk);
        ld_we_i  = 1'b0;
    endtask

    task automatic start_cmd(input logic [5:0] c, input logic [15:0] m, input logic u);
        @(negedge clk);
        b_nwr = nwr; b_rise = rises; b_gup = gup_n; b_done = done_n;
        start_cyc = cyc_n;
        count_i = c; target_mask_i = m; update_i = u;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_n == b_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished"}, 32'(done_n != b_done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err",  32'(err_o), 32'd0);
        check("rst_gup",  32'(global_update_o), 32'd0);
        check("rst_cyc",  32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
        check("rst_adr",  32'(wbm_adr_o), 32'd0);
        check("rst_dat",  wbm_dat_o, 32'd0);
        check("rst_sel",  32'(wbm_sel_o), 32'hF);
        rst_n = 1'b1;

        // Single write, ack latency 2
        stage(5'd0, 5'd1, 18'h00123);
        lat = 2;
        start_cmd(6'd1, 16'h0004, 1'b1);
        check("sw_busy", 32'(busy_o), 32'd1);
        wait_done("sw");
        check("sw_nwr",  32'(nwr - b_nwr), 32'd1);
        check("sw_adr",  32'(wr_adr[b_nwr % 64]), 32'h104);
        check("sw_dat",  wr_dat[b_nwr % 64], 32'h00000123);
        check("sw_run",  32'(runs[b_rise % 64]), 32'd3);
        check("sw_gupn", 32'(gup_n - b_gup), 32'd1);
        check("sw_gupc", 32'(gup_cyc - start_cyc), 32'd8);
        check("sw_donec", 32'(done_cyc - start_cyc), 32'd9);
        check("sw_err",  32'(err_o), 32'd0);
        check("sw_idle", 32'(busy_o), 32'd0);

        // Broadcast to targets 0 and 15, zero-latency slave
        stage(5'd0, 5'd3, 18'h11111);
        stage(5'd1, 5'd4, 18'h22222);
        stage(5'd2, 5'd5, 18'h3ffff);
        lat = 0;
        start_cmd(6'd3, 16'h8001, 1'b1);
        wait_done("bc");
        begin
            logic [10:0] ea [6];
            logic [31:0] ed [6];
            ea = '{11'h00C, 11'h010, 11'h014, 11'h78C, 11'h790, 11'h794};
            ed = '{32'h11111, 32'h22222, 32'h3ffff, 32'h11111, 32'h22222, 32'h3ffff};
            check("bc_nwr",  32'(nwr - b_nwr), 32'd6);
            check("bc_rise", 32'(rises - b_rise), 32'd6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("bc_adr%0d", i), 32'(wr_adr[(b_nwr + i) % 64]), 32'(ea[i]));
                check($sformatf("bc_dat%0d", i), wr_dat[(b_nwr + i) % 64], ed[i]);
                check($sformatf("bc_run%0d", i), 32'(runs[(b_rise + i) % 64]), 32'd1);
            end
        end
        check("bc_gupc",  32'(gup_cyc - start_cyc), 32'd22);
        check("bc_donec", 32'(done_cyc - start_cyc), 32'd23);

        // Ack timeout: stb held ACK_TIMEOUT+1 cycles
        ack_en = 1'b0;
        start_cmd(6'd1, 16'h0001, 1'b1);
        wait_done("to");
        check("to_run",  32'(runs[b_rise % 64]), 32'd5);
        check("to_err",  32'(err_o), 32'd1);
        check("to_gup",  32'(gup_n - b_gup), 32'd0);
        check("to_nwr",  32'(nwr - b_nwr), 32'd0);
        check("to_donec", 32'(done_cyc - start_cyc), 32'd8);
        ack_en = 1'b1;
        start_cmd(6'd0, 16'h0000, 1'b0);
        wait_done("clr");
        check("clr_err", 32'(err_o), 32'd0);
        check("clr_gup", 32'(gup_n - b_gup), 32'd0);

        // Bus error on second of three writes
        lat = 1;
        err_beat = beat + 1;
        start_cmd(6'd3, 16'h0002, 1'b1);
        wait_done("be");
        err_beat = -1;
        check("be_rise", 32'(rises - b_rise), 32'd2);
        check("be_nwr",  32'(nwr - b_nwr), 32'd1);
        check("be_adr",  32'(wr_adr[b_nwr % 64]), 32'h08C);
        check("be_err",  32'(err_o), 32'd1);
        check("be_gup",  32'(gup_n - b_gup), 32'd0);

        // Empty mask with update
        start_cmd(6'd2, 16'h0000, 1'b1);
        wait_done("m0");
        check("m0_gupc",  32'(gup_cyc - start_cyc), 32'd2);
        check("m0_donec", 32'(done_cyc - start_cyc), 32'd3);
        check("m0_rise",  32'(rises - b_rise), 32'd0);
        check("m0_err",   32'(err_o), 32'd0);

        // Zero count, two targets
        start_cmd(6'd0, 16'h0003, 1'b1);
        wait_done("c0");
        check("c0_rise",  32'(rises - b_rise), 32'd0);
        check("c0_gupn",  32'(gup_n - b_gup), 32'd1);
        check("c0_donec", 32'(done_cyc - start_cyc), 32'd5);

        // start_i and ld_we_i while busy are ignored
        stage(5'd0, 5'd2, 18'h0abcd);
        lat = 2;
        start_cmd(6'd1, 16'h0001, 1'b0);
        ld_we_i = 1'b1; ld_adr_i = 5'd0; ld_dat_i = {5'd7, 18'h3ffff};
        count_i = 6'd1; target_mask_i = 16'hFFFF; update_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        ld_we_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("bz");
        check("bz_nwr", 32'(nwr - b_nwr), 32'd1);
        check("bz_adr", 32'(wr_adr[b_nwr % 64]), 32'h008);
        check("bz_dat", wr_dat[b_nwr % 64], 32'h0000abcd);
        check("bz_gup", 32'(gup_n - b_gup), 32'd0);
        check("bz_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset during ISSUE
        ack_en = 1'b0;
        start_cmd(6'd1, 16'h0001, 1'b1);
        for (int i = 0; i < 10 && !wbm_stb_o; i++) @(negedge clk);
        check("rr_inissue", 32'(wbm_stb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_cyc",  32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("rr_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        start_cmd(6'd0, 16'h0000, 1'b1);
        wait_done("rr");
        check("rr_gupn",  32'(gup_n - b_gup), 32'd1);
        check("rr_donec", 32'(done_cyc - start_cyc), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
